serial_add_sub: RTL

- Parametrised bit-serial adder/subtractor. Successor to the team's single-bit combinational half adder.
- Processes WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Start/busy/done handshake; reports carry/borrow and signed overflow.
- Used where area matters more than latency, e.g. datapath demos and iterative arithmetic units.

---
 rtl/serial_add_sub_if.sv | 29 ++
 rtl/serial_add_sub.sv | 121 ++++++++++++
 2 files changed

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
//   start, sub, A, B              : requester -> adder (operation request)
//   busy, done, Sum, C_out,
//   overflow                      : adder -> requester (status and result)
// The master modport is the requester side; the slave modport is the adder.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
  logic             overflow;

  modport master (
    output start, sub, A, B,
    input  busy, done, Sum, C_out, overflow
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, Sum, C_out, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop
// process the WIDTH-bit operands LSB first, one bit per clock.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (wins over start, aborts a run)
//   bus  : serial_add_sub_if.slave
//          start/sub/A/B sampled only in IDLE;
//          busy high during RUN, done a one-cycle pulse in DONE;
//          Sum/C_out/overflow held until the next accepted start.
// Subtraction is A + ~B + 1: B is inverted at capture and the carry
// flip-flop is preloaded with 1, so C_out reads as NOT borrow.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst,
  serial_add_sub_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic             cout_r;
  logic             ovf_r;

  logic             s_s;
  logic             c_s;
  logic             last_s;

  // Carry of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Single full-adder cell on the current LSBs and detection of the MSB step.
  always_comb begin
    s_s    = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    c_s    = maj3(a_sh_r[0], b_sh_r[0], carry_r);
    last_s = (count_r == CW'(WIDTH - 1));
  end

  // Control FSM and serial datapath with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      count_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r  <= bus.A;
            b_sh_r  <= bus.sub ? ~bus.B : bus.B;
            carry_r <= bus.sub;
            count_r <= '0;
            sum_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_r   <= {s_s, sum_r[WIDTH-1:1]};
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= c_s;
          if (last_s) begin
            // carry_r here is still the carry into the MSB.
            cout_r  <= c_s;
            ovf_r   <= carry_r ^ c_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            // Counter stops at WIDTH-1, so it never wraps.
            count_r <= count_r + CW'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.Sum      = sum_r;
  assign bus.C_out    = cout_r;
  assign bus.overflow = ovf_r;

endmodule
